// File: rtl/mem_burst_reader_if.sv
// Bus bundle for mem_burst_reader: the ram-side read port and the
// valid/ready output stream.
//   master : the burst reader (drives ram address/cs/web, stream data/valid)
//   slave  : the environment (drives ram q, stream ready)
interface mem_burst_reader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_web;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mem_addr, mem_cs, mem_web, out_data, out_valid,
        input  mem_q, out_ready
    );

    modport slave (
        input  mem_addr, mem_cs, mem_web, out_data, out_valid,
        output mem_q, out_ready
    );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst read engine: reads len consecutive ram words starting at base_addr
// and streams them over valid/ready through a DEPTH-entry FIFO, so the
// ram read sequence only pauses when the FIFO is full.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             burst request (sampled only while idle)
//   base_addr, len    burst first address / word count, captured on start
//   busy, done        burst in progress / one-cycle end-of-burst pulse
//   bus (master)      mem_addr/mem_cs/mem_web/mem_q ram port,
//                     out_data/out_valid/out_ready stream
module mem_burst_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    mem_burst_reader_if.master    bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] fifo [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count, count_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [LEN_WIDTH-1:0]  len_q, issued, issued_nxt, popped, popped_nxt;
    logic                  push, pop;

    // mem_cs is registered and only ever high in READ, so an asserted cs
    // always means "this cycle's mem_q goes into the FIFO".
    assign push          = bus.mem_cs;
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = fifo[rptr];
    assign bus.mem_web   = 1'b1;

    assign count_nxt    = count + CW'(push) - CW'(pop);
    assign cur_addr_nxt = cur_addr + ADDR_WIDTH'(push);  // wraps mod 2^ADDR_WIDTH
    assign issued_nxt   = issued + LEN_WIDTH'(push);
    assign popped_nxt   = popped + LEN_WIDTH'(pop);

    // Output FIFO; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (push) begin
                fifo[wptr] <= bus.mem_q;
                wptr       <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Control FSM. mem_cs/mem_addr are decided one cycle ahead from the
    // post-edge FIFO occupancy, so out_ready never reaches the ram port
    // combinationally and a pop only frees issue space for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.mem_cs   <= 1'b0;
            bus.mem_addr <= '0;
            cur_addr     <= '0;
            len_q        <= '0;
            issued       <= '0;
            popped       <= '0;
        end else begin
            cur_addr <= cur_addr_nxt;
            issued   <= issued_nxt;
            popped   <= popped_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        issued   <= '0;
                        popped   <= '0;
                        cur_addr <= base_addr;
                        busy     <= 1'b1;
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= S_READ;
                            bus.mem_cs   <= 1'b1;
                            bus.mem_addr <= base_addr;
                        end
                    end
                end
                S_READ: begin
                    if (issued_nxt == len_q) begin
                        state      <= S_DRAIN;
                        bus.mem_cs <= 1'b0;
                    end else begin
                        bus.mem_cs <= (count_nxt < FULL);
                        // Address only moves when a read will actually issue.
                        if (count_nxt < FULL) bus.mem_addr <= cur_addr_nxt;
                    end
                end
                S_DRAIN: begin
                    // The last word is pushed on the READ->DRAIN edge, so at
                    // least one pop always happens here.
                    if (popped_nxt == len_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
module tb_mem_burst_reader;
    localparam int DW = 64;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy, done;

    mem_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    mem_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:65535];
    assign bus.mem_q = ram[bus.mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ready driver
    int stall_left = 0;
    bit rand_mode = 0;
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else begin
            bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Behavioural model: a burst is a queue of expected words; occupancy is
    // words issued minus words taken; the ram is read whenever there is room.
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] prev_data, first_pop, wexp;
    int  cyc = 0, start_cyc = 0, rel;
    int  issued_m, popped_m, len_m, occ;
    int  first_valid_rel, done_rel, cs_cnt, cs_early;
    bit  m_busy, m_done, cs_exp, pop_m, nb, nd, prev_stall;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; exp_q.delete();
            issued_m = 0; popped_m = 0; len_m = 0; prev_stall = 0;
        end else begin
            rel = cyc - start_cyc;
            occ = issued_m - popped_m;
            cs_exp = m_busy && !m_done && (issued_m < len_m) && (occ < DEPTH);
            pop_m  = (occ > 0) && bus.out_ready;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("mem_web", bus.mem_web, 1'b1);
            chk("mem_cs", bus.mem_cs, cs_exp);
            chk("out_valid", bus.out_valid, occ > 0);
            if (cs_exp) chk("mem_addr", bus.mem_addr, exp_addr);
            if (prev_stall) chk("stall_data", bus.out_data, prev_data);
            if (pop_m) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_data: got %h expected no word", bus.out_data);
                end else begin
                    wexp = exp_q.pop_front();
                    if (popped_m == 0) first_pop = bus.out_data;
                    chk("out_data", bus.out_data, wexp);
                end
                popped_m++;
            end
            if (bus.out_valid && first_valid_rel < 0) first_valid_rel = rel;
            if (done && done_rel < 0) done_rel = rel;
            if (bus.mem_cs) begin
                cs_cnt++;
                addr_log.push_back(bus.mem_addr);
                if (rel <= 9) cs_early++;
            end
            if (cs_exp) begin issued_m++; exp_addr++; end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            nb = m_busy; nd = 0;
            if (m_done) nb = 0;
            else if (!m_busy && start) begin
                start_cyc = cyc; first_valid_rel = -1; done_rel = -1;
                cs_cnt = 0; cs_early = 0; addr_log.delete(); exp_q.delete();
                len_m = int'(len); issued_m = 0; popped_m = 0; exp_addr = base_addr;
                for (int k = 0; k < len_m; k++) exp_q.push_back(ram[AW'(base_addr + AW'(k))]);
                nb = 1; nd = (len == '0);
            end else if (m_busy && pop_m && popped_m == len_m) nd = 1;
            m_busy = nb; m_done = nd;
        end
    end

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done within %0d cycles", limit);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l,
                             input int stall, input bit rnd, input bit interject);
        @(negedge clk);
        stall_left = stall; rand_mode = rnd;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        if (interject) begin
            repeat (15) @(posedge clk);
            #1 start = 1'b1; base_addr = '0; len = 16'd5;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(3000);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_cs"}, bus.mem_cs, 1'b0);
        chk({tag, "_addr"}, bus.mem_addr, '0);
        chk({tag, "_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_data"}, bus.out_data, '0);
        chk({tag, "_web"}, bus.mem_web, 1'b1);
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        for (int i = 0; i < 65536; i++) ram[i] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) ram[16'h10 + i] = 64'hA0 + 64'(i);
        #2 chk_reset_outs("reset");
        #10 rst_n = 1'b1;

        // 1: straight burst, consumer always ready
        run_burst(16'h0010, 16'd8, 0, 0, 0);
        chk("t1_first_valid", 64'(first_valid_rel), 64'd2);
        chk("t1_done_cycle", 64'(done_rel), 64'd10);
        chk("t1_cs_cycles", 64'(cs_cnt), 64'd8);
        chk("t1_first_word", first_pop, 64'hA0);

        // 2: consumer stalled for cycles 0-9
        run_burst(16'h0010, 16'd8, 10, 0, 0);
        chk("t2_cs_during_stall", 64'(cs_early), 64'd4);
        chk("t2_done_cycle", 64'(done_rel), 64'd18);
        chk("t2_first_word", first_pop, 64'hA0);

        // 3: address wrap
        run_burst(16'hFFFE, 16'd4, 0, 0, 0);
        chk("t3_addr_count", 64'(addr_log.size()), 64'd4);
        if (addr_log.size() == 4) begin
            chk("t3_addr0", 64'(addr_log[0]), 64'hFFFE);
            chk("t3_addr1", 64'(addr_log[1]), 64'hFFFF);
            chk("t3_addr2", 64'(addr_log[2]), 64'h0000);
            chk("t3_addr3", 64'(addr_log[3]), 64'h0001);
        end

        // 4: zero-length burst
        run_burst(16'h0123, 16'd0, 0, 0, 0);
        chk("t4_cs_cycles", 64'(cs_cnt), 64'd0);
        chk("t4_done_cycle", 64'(done_rel), 64'd1);
        chk("t4_no_valid", 64'(first_valid_rel), 64'hFFFF_FFFF_FFFF_FFFF);

        // 5: random back-pressure, long burst, ignored start while busy
        run_burst(16'h4000, 16'd100, 0, 1, 1);
        chk("t5_cs_cycles", 64'(cs_cnt), 64'd100);
        for (int k = 0; k < 3; k++)
            run_burst(16'($urandom), 16'($urandom_range(1, 40)), $urandom_range(0, 6), 1, 0);

        // 6: reset in the middle of a burst
        @(negedge clk);
        stall_left = 0; rand_mode = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0100; len = 16'd20;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (popped_m >= 3) begin hit = 1; break; end
        end
        chk("t6_three_out", 64'(hit), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outs("midreset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run_burst(16'h0200, 16'd2, 0, 0, 0);
        chk("t6_cs_cycles", 64'(cs_cnt), 64'd2);
        chk("t6_done_cycle", 64'(done_rel), 64'd4);
        chk("t6_first_word", first_pop, ram[16'h0200]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
